lpc_autocorrelation: RTL and testbench
======================================

# lpc_autocorrelation

Frame autocorrelation engine for the LPC encoder, directly upstream of the Levinson-Durbin stage. After `start`, it reads one frame of N signed samples from the shared sample memory and computes lags r[0..P] with a single time-multiplexed multiply-accumulate. It writes each lag to the autocorrelation memory, then holds `ready` high for the encoder controller.

## Interface
Parameters:
- N, 240: frame length in samples.
- P, 10: LPC order. Lags 0..P are produced. Constraint: P < N.
- DW, 16: sample width, signed two's complement.
- RW, 32: output lag width, signed.
- SHIFT, 8: arithmetic right shift applied to the accumulator before output.
- AW, $clog2(N): sample address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame computation.
- x_raddr  out  AW  sample memory read address. The memory is muxed to this block while the controller selects the autocorrelation source.
- x_rdata  in  DW  sample read data; synchronous read, valid 1 cycle after address.
- r_wen  out  1  autocorrelation memory write strobe.
- r_waddr  out  $clog2(P+1)  lag index written.
- r_wdata  out  RW  lag value.
- ready  out  1  high while results are complete; consumed as ready_autocorrelation.

## Operation
- Computes r[k] = sum over n=k..N-1 of x[n]·x[n−k], for k = 0..P.
- Accumulator is signed, ACC_W = 2·DW + $clog2(N) bits; no overflow is possible in it.
- Output value: r_wdata = sat_RW(acc >>> SHIFT). The shift is arithmetic (floor). Saturation clamps to 2^(RW−1)−1 and −2^(RW−1).
- FSM states: IDLE, RUN_A, RUN_B, DRAIN, WRITE, DONE.
  - IDLE: on start, set k=0, n=0, acc=0, pend=0, then go to RUN_A.
  - RUN_A: x_raddr=n. If pend, acc += xa·x_rdata. Go to RUN_B.
  - RUN_B: x_raddr=n−k; xa<=x_rdata; pend<=1. If n==N−1, go to DRAIN; else n<=n+1 and go to RUN_A.
  - DRAIN: acc += xa·x_rdata; go to WRITE.
  - WRITE: r_wen=1, r_waddr=k, r_wdata from acc; then acc<=0 and pend<=0. If k==P, go to DONE; else k<=k+1, n<=k+1, go to RUN_A.
  - DONE: ready=1. On start, restart exactly as from IDLE; ready drops the next cycle.
- start is ignored in RUN_A, RUN_B, DRAIN and WRITE.
- x_raddr outside RUN_A and RUN_B is 0, and is don't-care to the mux.
- Multiplier: one DW×DW signed multiplier, used on the RUN_A and DRAIN cycles.

## Timing
- Reset values: state=IDLE, ready=0, r_wen=0, r_waddr=0, r_wdata=0, x_raddr=0, acc=0.
- Reset mid-operation aborts the frame. No further r_wen pulses occur, and ready stays 0 until a full new frame completes.
- Start latency: start sampled high in cycle t puts the FSM in RUN_A at t+1.
- Cycles per lag: 2·(N−k)+2.
- Total from the first RUN_A to the last WRITE: 2·(P+1)·(N+1) − P·(P+1) = 5192 at the defaults.
- ready rises the cycle after the last WRITE. It stays high until reset or a new start.
- Exactly P+1 write strobes per frame, in ascending lag order, each one cycle wide. They are never back-to-back, since at least 2 RUN cycles separate them.
- Lag k=P with N−P samples is the shortest lag. The boundary n==N−1 must still produce its final product via DRAIN.

## Structure
- Shared package lpc_pkg holds: the frame/order constants (N, P, DW, RW) that are common with Levinson and the inverse filter, ACC_W, and the FSM state enum.
- One natural sub-module: lpc_mac_sat. It contains the signed multiply-accumulate with clear, arithmetic shift and RW saturation, and is reusable by the inverse filter.

## Test plan
- All-zero frame, start → five-lag-free check: 11 writes with r_wdata=0; ready high exactly 5192 cycles after the first RUN_A cycle.
- Constant x[n]=256 → r[k]=256·(240−k). Expect r[0]=61440 and r[10]=58880; writes in order 0..10.
- Impulse x[0]=1000, rest 0 → r[0]=3906 (floor of 1e6/256), r[1..10]=0.
- Saturation: override SHIFT=0 with all x=−32768 → r[0..10] all 0x7FFFFFFF; ready still asserts.
- Reset asserted mid-lag 5 → no further r_wen and ready=0. A fresh start with the ramp x[n]=n−120 must then match the golden model for all lags.
- start pulsed during RUN and again in DONE → the first is ignored. The second restarts: ready falls the next cycle and a full frame rewrites all 11 lags.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared LPC constants and the autocorrelation FSM state type.
// The frame and order constants are common with the Levinson and inverse-filter blocks.
package lpc_pkg;

  localparam int LPC_N     = 240;
  localparam int LPC_P     = 10;
  localparam int LPC_DW    = 16;
  localparam int LPC_RW    = 32;
  localparam int LPC_SHIFT = 8;

  // Wide enough to hold N full-scale products without overflow.
  localparam int LPC_ACC_W = 2 * LPC_DW + $clog2(LPC_N);

  typedef enum logic [2:0] {
    IDLE,
    RUN_A,
    RUN_B,
    DRAIN,
    WRITE,
    DONE
  } ac_state_e;

endpackage

// File: rtl/lpc_mac_sat.sv
// Signed multiply-accumulate with synchronous clear, followed by an
// arithmetic right shift and saturation to RW bits.
module lpc_mac_sat #(
  parameter int DW    = 16,
  parameter int RW    = 32,
  parameter int ACC_W = 40,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [RW-1:0] sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-RW+1){1'b1}}, {(RW-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] shifted;

  // Multiply, accumulate, and clamp the shifted result to the output range.
  always_comb begin
    prod     = a_i * b_i;
    prod_ext = $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
    acc_d    = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
    shifted = acc_q >>> SHIFT;
    if (shifted > MAX_V) begin
      sat_o = MAX_V[RW-1:0];
    end else if (shifted < MIN_V) begin
      sat_o = MIN_V[RW-1:0];
    end else begin
      sat_o = shifted[RW-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/lpc_autocorrelation.sv
// Frame autocorrelation engine: reads N samples per lag from the shared
// sample memory and writes r[0..P] through one time-shared MAC.
// Each product takes a RUN_A/RUN_B pair: RUN_A fetches x[n], RUN_B fetches
// x[n-k] while latching x[n]; the product lands in the following RUN_A or DRAIN.
module lpc_autocorrelation
  import lpc_pkg::*;
#(
  parameter int N     = LPC_N,
  parameter int P     = LPC_P,
  parameter int DW    = LPC_DW,
  parameter int RW    = LPC_RW,
  parameter int SHIFT = LPC_SHIFT,
  parameter int AW    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [AW-1:0]            x_raddr,
  input  logic signed [DW-1:0]     x_rdata,
  output logic                     r_wen,
  output logic [$clog2(P+1)-1:0]   r_waddr,
  output logic signed [RW-1:0]     r_wdata,
  output logic                     ready
);

  localparam int KW    = $clog2(P + 1);
  localparam int ACC_W = 2 * DW + $clog2(N);

  ac_state_e            state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [AW-1:0]        n_q, n_d;
  logic signed [DW-1:0] xa_q, xa_d;
  logic                 pend_q, pend_d;
  logic                 mac_clr, mac_en;
  logic signed [RW-1:0] sat_w;

  lpc_mac_sat #(
    .DW   (DW),
    .RW   (RW),
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (xa_q),
    .b_i  (x_rdata),
    .sat_o(sat_w)
  );

  // Next-state and output decode; outputs idle at zero outside their states.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    xa_d    = xa_q;
    pend_d  = pend_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    x_raddr = '0;
    r_wen   = 1'b0;
    r_waddr = '0;
    r_wdata = '0;
    ready   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        ready = (state_q == DONE);
        if (start) begin
          k_d     = '0;
          n_d     = '0;
          pend_d  = 1'b0;
          mac_clr = 1'b1;
          state_d = RUN_A;
        end
      end
      RUN_A: begin
        x_raddr = n_q;
        mac_en  = pend_q;
        state_d = RUN_B;
      end
      RUN_B: begin
        x_raddr = n_q - AW'(k_q);
        xa_d    = x_rdata;
        pend_d  = 1'b1;
        if (n_q == AW'(N - 1)) begin
          state_d = DRAIN;
        end else begin
          n_d     = n_q + AW'(1);
          state_d = RUN_A;
        end
      end
      DRAIN: begin
        mac_en  = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        r_wen   = 1'b1;
        r_waddr = k_q;
        r_wdata = sat_w;
        mac_clr = 1'b1;
        pend_d  = 1'b0;
        if (k_q == KW'(P)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          n_d     = AW'(k_q) + AW'(1);
          state_d = RUN_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      xa_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      xa_q    <= xa_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_lpc_autocorrelation.sv
// Testbench for lpc_autocorrelation: table-driven frames, saturation,
// mid-frame reset, randomized frames and start handling.
module tb_lpc_autocorrelation;

  localparam int N     = 240;
  localparam int P     = 10;
  localparam int TOTAL = 2 * (P + 1) * (N + 1) - P * (P + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset  = 1'b1;
  logic               start0 = 1'b0;
  logic               start1 = 1'b0;
  logic [7:0]         xa0, xa1;
  logic signed [15:0] xd0, xd1;
  logic               wen0, wen1;
  logic [3:0]         wa0, wa1;
  logic signed [31:0] wd0, wd1;
  logic               rdy0, rdy1;

  logic signed [15:0] mem [0:N-1];

  lpc_autocorrelation dut (
    .clk(clk), .reset(reset), .start(start0), .x_raddr(xa0), .x_rdata(xd0),
    .r_wen(wen0), .r_waddr(wa0), .r_wdata(wd0), .ready(rdy0)
  );

  lpc_autocorrelation #(.SHIFT(0)) dut_s (
    .clk(clk), .reset(reset), .start(start1), .x_raddr(xa1), .x_rdata(xd1),
    .r_wen(wen1), .r_waddr(wa1), .r_wdata(wd1), .ready(rdy1)
  );

  // Synchronous-read sample memory, one port per DUT.
  always @(posedge clk) begin
    xd0 <= mem[xa0];
    xd1 <= mem[xa1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];

  // Record every write strobe of the selected DUT with its cycle stamp.
  always @(negedge clk) begin
    if (sel == 0 ? wen0 : wen1) begin
      q_addr.push_back(sel == 0 ? int'(wa0) : int'(wa1));
      q_data.push_back(sel == 0 ? int'(wd0) : int'(wd1));
      q_cyc.push_back(cyc);
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  // Golden lag value straight from the definition of r[k].
  function automatic longint model_r(input int k, input int sh);
    longint acc = 0;
    longint v;
    for (int n = k; n < N; n++) acc += longint'(mem[n]) * longint'(mem[n-k]);
    v = acc >>> sh;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v;
  endfunction

  function automatic longint got_lag(input int b, input int k);
    if (b + k < q_data.size()) return longint'(q_data[b+k]);
    return -64'sd999999999999;
  endfunction

  function automatic bit rdy(input int s);
    return (s == 0) ? rdy0 : rdy1;
  endfunction

  task automatic do_start(input int s, output int e);
    @(negedge clk);
    if (s == 0) start0 = 1'b1;
    else start1 = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_ready(input int s, input int e, input string name);
    int n = 0;
    while (!rdy(s) && n < 7000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready cycle"}, rdy(s) ? longint'(cyc - e) : -1, TOTAL);
  endtask

  task automatic check_writes(input int e, input int b, input int sh, input string name);
    int cnt = q_addr.size() - b;
    int t = e - 1;
    chk({name, " write count"}, cnt, P + 1);
    for (int k = 0; k <= P; k++) begin
      t += 2 * (N - k) + 2;
      if (k < cnt) begin
        chk($sformatf("%s lag%0d addr", name, k), q_addr[b+k], k);
        chk($sformatf("%s lag%0d data", name, k), q_data[b+k], model_r(k, sh));
        chk($sformatf("%s lag%0d cycle", name, k), q_cyc[b+k] - e, t - e);
      end
    end
  endtask

  task automatic run_frame(input string name);
    int e, b;
    b = q_addr.size();
    do_start(0, e);
    wait_ready(0, e, name);
    check_writes(e, b, 8, name);
  endtask

  typedef struct {
    string  name;
    int     kind;   // 0 zero, 1 constant val, 2 impulse of val at x[0]
    int     val;
    longint r0;
    longint r1;
    longint r10;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int e, b, b2, cnt, n, seen_rdy;

    tbl[0] = '{"zero",     0, 0,    0,        0,        0};
    tbl[1] = '{"c256",     1, 256,  61440,    61184,    58880};
    tbl[2] = '{"cm256",    1, -256, 61440,    61184,    58880};
    tbl[3] = '{"c4096",    1, 4096, 15728640, 15663104, 15073280};
    tbl[4] = '{"impulse",  2, 1000, 3906,     0,        0};

    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst ready", rdy0, 0);
    chk("rst r_wen", wen0, 0);
    chk("rst r_waddr", wa0, 0);
    chk("rst r_wdata", wd0, 0);
    chk("rst x_raddr", xa0, 0);
    chk("rst ready_sat", rdy1, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) begin
        case (tbl[i].kind)
          1:       mem[j] = 16'(tbl[i].val);
          2:       mem[j] = (j == 0) ? 16'(tbl[i].val) : 16'sd0;
          default: mem[j] = 16'sd0;
        endcase
      end
      b = q_addr.size();
      do_start(0, e);
      wait_ready(0, e, tbl[i].name);
      check_writes(e, b, 8, tbl[i].name);
      chk({tbl[i].name, " r0"},  got_lag(b, 0),  tbl[i].r0);
      chk({tbl[i].name, " r1"},  got_lag(b, 1),  tbl[i].r1);
      chk({tbl[i].name, " r10"}, got_lag(b, 10), tbl[i].r10);
      $display("frame %s r0=%0d r1=%0d r10=%0d", tbl[i].name, got_lag(b, 0), got_lag(b, 1), got_lag(b, 10));
    end

    // Saturation on the SHIFT=0 instance.
    for (int j = 0; j < N; j++) mem[j] = -16'sd32768;
    sel = 1;
    @(negedge clk);
    b = q_addr.size();
    do_start(1, e);
    wait_ready(1, e, "sat");
    check_writes(e, b, 0, "sat");
    chk("sat r0", got_lag(b, 0), 64'sd2147483647);
    chk("sat r10", got_lag(b, 10), 64'sd2147483647);
    $display("frame sat r0=%0d r10=%0d", got_lag(b, 0), got_lag(b, 10));
    sel = 0;
    @(negedge clk);

    // Reset during lag 5 aborts the frame.
    for (int j = 0; j < N; j++) mem[j] = 16'($urandom);
    b = q_addr.size();
    do_start(0, e);
    n = 0;
    while (q_addr.size() - b < 5 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("abort lags before reset", q_addr.size() - b, 5);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b2 = q_addr.size();
    seen_rdy = 0;
    repeat (600) begin
      @(negedge clk);
      if (rdy0) seen_rdy = 1;
    end
    chk("abort writes after reset", q_addr.size() - b2, 0);
    chk("abort ready", seen_rdy, 0);
    $display("abort writes_after=%0d ready_seen=%0d", q_addr.size() - b2, seen_rdy);

    // Ramp frame after the abort.
    for (int j = 0; j < N; j++) mem[j] = 16'(j - 120);
    run_frame("ramp");
    $display("frame ramp r0=%0d", got_lag(q_data.size() - (P + 1), 0));

    // Randomized frames: full-range and small-amplitude.
    for (int j = 0; j < N; j++) mem[j] = 16'($urandom);
    run_frame("rand_full");
    $display("frame rand_full done");
    for (int j = 0; j < N; j++) mem[j] = 16'(int'($urandom_range(0, 200)) - 100);
    run_frame("rand_small");
    $display("frame rand_small done");

    // start during RUN is ignored; start in DONE restarts.
    for (int j = 0; j < N; j++) mem[j] = 16'(int'($urandom_range(0, 4000)) - 2000);
    b = q_addr.size();
    do_start(0, e);
    repeat (100) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_ready(0, e, "ignored");
    check_writes(e, b, 8, "ignored");
    repeat (20) @(negedge clk);
    chk("done ready holds", rdy0, 1);
    for (int j = 0; j < N; j++) mem[j] = 16'(int'($urandom_range(0, 4000)) - 2000);
    b = q_addr.size();
    do_start(0, e);
    chk("restart ready drop", rdy0, 0);
    wait_ready(0, e, "restart");
    check_writes(e, b, 8, "restart");
    cnt = q_addr.size() - b;
    $display("frame restart writes=%0d", cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
